// File: rtl/vga_pkg.sv
// Shared types and mode presets for the VGA timing core.
// Pure declarations: no logic, no latency, no stall behaviour.
package vga_pkg;

    localparam int COORD_W      = 12;
    localparam int MAX_TOT      = 4096;
    localparam int MAX_PIPE_LAT = 15;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        h_active: 640,  h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480,  v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol: 1'b0,   vs_pol: 1'b0
    };

    // 148.5 MHz pixel clock
    localparam vga_mode_t VGA_1920x1080_60 = '{
        h_active: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
        v_active: 1080, v_fp: 4,  v_sync: 5,  v_bp: 36,
        hs_pol: 1'b1,   vs_pol: 1'b1
    };

endpackage

// File: rtl/vga_timing_core_if.sv
// Pixel-request bus between the timing core and the colour pipeline.
// Coordinates leave combinationally; colour returns PIPE_LAT ticks later.
interface vga_timing_core_if #(
    parameter int COLOR_W = 4
);
    import vga_pkg::*;

    coord_t             req_x;
    coord_t             req_y;
    logic               req_valid;
    logic               line_start;
    logic               frame_start;
    logic [COLOR_W-1:0] red_in;
    logic [COLOR_W-1:0] green_in;
    logic [COLOR_W-1:0] blue_in;

    modport master (
        output req_x, req_y, req_valid, line_start, frame_start,
        input  red_in, green_in, blue_in
    );

    modport slave (
        input  req_x, req_y, req_valid, line_start, frame_start,
        output red_in, green_in, blue_in
    );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages, reset to RST_VAL.
// Latency DEPTH enabled ticks (DEPTH=0 is a wire); holds while en is low.
module vga_delay_line #(
    parameter int                DEPTH   = 2,
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = ^{clk, reset, en};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator with delay-matched sync/blank and colour output register.
// Request-to-pin latency PIPE_LAT+1 pixel ticks; everything holds while pix_en is low.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640x480_60.h_active,
    parameter int H_FP     = VGA_640x480_60.h_fp,
    parameter int H_SYNC   = VGA_640x480_60.h_sync,
    parameter int H_BP     = VGA_640x480_60.h_bp,
    parameter int V_ACTIVE = VGA_640x480_60.v_active,
    parameter int V_FP     = VGA_640x480_60.v_fp,
    parameter int V_SYNC   = VGA_640x480_60.v_sync,
    parameter int V_BP     = VGA_640x480_60.v_bp,
    parameter bit HS_POL   = VGA_640x480_60.hs_pol,
    parameter bit VS_POL   = VGA_640x480_60.vs_pol,
    parameter int COLOR_W  = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    vga_timing_core_if.master  req,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOT > MAX_TOT || V_TOT > MAX_TOT) begin : g_bad_tot
            $fatal(1, "vga_timing_core: H_TOT/V_TOT exceed the 12-bit counter range");
        end
        if (PIPE_LAT < 0 || PIPE_LAT > MAX_PIPE_LAT) begin : g_bad_lat
            $fatal(1, "vga_timing_core: PIPE_LAT must be 0..15");
        end
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
            $fatal(1, "vga_timing_core: porch and sync widths must be at least 1");
        end
        if (H_ACTIVE < 1 || V_ACTIVE < 1 || COLOR_W < 1) begin : g_bad_size
            $fatal(1, "vga_timing_core: active area and COLOR_W must be at least 1");
        end
    endgenerate

    localparam coord_t H_LAST    = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOT - 1);
    localparam coord_t H_ACT_END = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_END = coord_t'(V_ACTIVE);
    localparam coord_t HS_START  = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END    = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START  = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END    = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    // Delay stages carry pin levels so their reset value is simply "sync inactive"
    localparam logic [2:0] DLY_RST = {1'b0, ~HS_POL, ~VS_POL};

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    coord_t     h_cnt;
    coord_t     v_cnt;
    logic       valid_c;
    logic       hs_lvl;
    logic       vs_lvl;
    logic [2:0] dly_q;
    logic       dly_valid;
    logic       dly_hs;
    logic       dly_vs;
    rgb_t       pix_d;
    rgb_t       pix_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        valid_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_lvl  = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        vs_lvl  = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    end

    assign req.req_x       = h_cnt;
    assign req.req_y       = v_cnt;
    assign req.req_valid   = valid_c;
    assign req.line_start  = (h_cnt == '0);
    assign req.frame_start = (h_cnt == '0) && (v_cnt == '0);

    vga_delay_line #(
        .DEPTH   (PIPE_LAT),
        .WIDTH   (3),
        .RST_VAL (DLY_RST)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .d     ({valid_c, hs_lvl, vs_lvl}),
        .q     (dly_q)
    );

    assign {dly_valid, dly_hs, dly_vs} = dly_q;

    // Blanking is forced here; upstream colour outside the active area is ignored
    always_comb begin
        pix_d = '0;
        if (dly_valid) begin
            pix_d.r = req.red_in;
            pix_d.g = req.green_in;
            pix_d.b = req.blue_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de    <= 1'b0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            pix_q <= '0;
        end else if (pix_en) begin
            de    <= dly_valid;
            hsync <= dly_hs;
            vsync <= dly_vs;
            pix_q <= pix_d;
        end
    end

    assign red   = pix_q.r;
    assign green = pix_q.g;
    assign blue  = pix_q.b;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: a small mode, two instances (PIPE_LAT=2 active-low, PIPE_LAT=0 active-high).
module tb_vga_timing_core;
    import vga_pkg::*;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CW = 4;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;
    always #5 clk = ~clk;

    vga_timing_core_if #(.COLOR_W(CW)) ifa ();
    vga_timing_core_if #(.COLOR_W(CW)) ifb ();

    logic hs_a, vs_a, de_a, hs_b, vs_b, de_b;
    logic [CW-1:0] r_a, g_a, b_a, r_b, g_b, b_b;

    vga_timing_core #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .PIPE_LAT(LAT_A)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .req(ifa),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .red(r_a), .green(g_a), .blue(b_a)
    );

    vga_timing_core #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(CW), .PIPE_LAT(LAT_B)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .req(ifb),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .red(r_b), .green(g_b), .blue(b_b)
    );

    // Request record; hs/vs are "inside window" flags, independent of polarity
    typedef struct {
        logic          valid;
        logic          hs;
        logic          vs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } req_t;

    typedef struct {
        logic          de;
        logic          hsync;
        logic          vsync;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } pin_t;

    typedef struct {
        logic r;
        logic e;
        int   h;
        int   v;
        logic ls;
        logic fs;
        logic de;
    } vec_t;

    req_t hist[$];
    pin_t sb_a[$];
    pin_t sb_b[$];
    int   mh = 0;
    int   mv = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic req_t blank_req();
        req_t q;
        q.valid = 1'b0; q.hs = 1'b0; q.vs = 1'b0; q.x = '0; q.y = '0;
        return q;
    endfunction

    task automatic hist_reset();
        hist.delete();
        for (int i = 0; i < 16; i++) hist.push_back(blank_req());
    endtask

    function automatic req_t cur_req();
        req_t q;
        q.valid = (mh < HA) && (mv < VA);
        q.hs    = (mh >= HA + HF) && (mh < HA + HF + HS);
        q.vs    = (mv >= VA + VF) && (mv < VA + VF + VS);
        q.x     = mh[CW-1:0];
        q.y     = mv[CW-1:0];
        return q;
    endfunction

    function automatic req_t dly(input int lat, input req_t cur);
        if (lat == 0) return cur;
        return hist[hist.size() - lat];
    endfunction

    function automatic pin_t mk_pins(input req_t d, input logic hp, input logic vp,
                                     input logic [CW-1:0] ri, input logic [CW-1:0] gi,
                                     input logic [CW-1:0] bi);
        pin_t p;
        p.de    = d.valid;
        p.hsync = d.hs ? hp : ~hp;
        p.vsync = d.vs ? vp : ~vp;
        p.r     = d.valid ? ri : '0;
        p.g     = d.valid ? gi : '0;
        p.b     = d.valid ? bi : '0;
        return p;
    endfunction

    function automatic pin_t rst_pins(input logic hp, input logic vp);
        pin_t p;
        p.de = 1'b0; p.hsync = ~hp; p.vsync = ~vp; p.r = '0; p.g = '0; p.b = '0;
        return p;
    endfunction

    pin_t pins_a, pins_b;

    // One clock: drive inputs, push expected pins, edge, then pop and compare
    task automatic step(input logic r, input logic e);
        req_t cur, da, db;
        pin_t pa, pb;
        cur = cur_req();
        da  = dly(LAT_A, cur);
        db  = dly(LAT_B, cur);
        reset  = r;
        pix_en = e;
        ifa.red_in = da.x; ifa.green_in = da.y; ifa.blue_in = CW'($urandom);
        ifb.red_in = db.x; ifb.green_in = db.y; ifb.blue_in = CW'($urandom);
        if (r) begin
            pa = rst_pins(1'b0, 1'b0);
            pb = rst_pins(1'b1, 1'b1);
        end else if (e) begin
            pa = mk_pins(da, 1'b0, 1'b0, ifa.red_in, ifa.green_in, ifa.blue_in);
            pb = mk_pins(db, 1'b1, 1'b1, ifb.red_in, ifb.green_in, ifb.blue_in);
        end else begin
            pa = pins_a;
            pb = pins_b;
        end
        sb_a.push_back(pa);
        sb_b.push_back(pb);
        @(posedge clk);
        #1;
        if (r) begin
            mh = 0; mv = 0;
            hist_reset();
        end else if (e) begin
            hist.push_back(cur);
            void'(hist.pop_front());
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
        pins_a = sb_a.pop_front();
        pins_b = sb_b.pop_front();
        chk("a_de", int'(de_a), int'(pins_a.de));
        chk("a_hsync", int'(hs_a), int'(pins_a.hsync));
        chk("a_vsync", int'(vs_a), int'(pins_a.vsync));
        chk("a_red", int'(r_a), int'(pins_a.r));
        chk("a_green", int'(g_a), int'(pins_a.g));
        chk("a_blue", int'(b_a), int'(pins_a.b));
        chk("b_de", int'(de_b), int'(pins_b.de));
        chk("b_hsync", int'(hs_b), int'(pins_b.hsync));
        chk("b_vsync", int'(vs_b), int'(pins_b.vsync));
        chk("b_red", int'(r_b), int'(pins_b.r));
        chk("b_green", int'(g_b), int'(pins_b.g));
        chk("b_blue", int'(b_b), int'(pins_b.b));
        chk("a_req_x", int'(ifa.req_x), mh);
        chk("a_req_y", int'(ifa.req_y), mv);
        chk("a_req_valid", int'(ifa.req_valid), int'((mh < HA) && (mv < VA)));
        chk("a_line_start", int'(ifa.line_start), int'(mh == 0));
        chk("a_frame_start", int'(ifa.frame_start), int'(mh == 0 && mv == 0));
        chk("b_req_x", int'(ifb.req_x), mh);
        chk("b_req_y", int'(ifb.req_y), mv);
        chk("b_frame_start", int'(ifb.frame_start), int'(mh == 0 && mv == 0));
    endtask

    initial begin
        vec_t tbl[8];
        int n_hs_a, n_vs_a, n_de_a, n_hs_b, n_vs_b, n_de_b, n_ls, n_fs;
        int prev_ls, prev_fs, ls_rise[$], fs_rise[$];
        int first_a, first_b;

        reset = 1'b1;
        pix_en = 1'b0;
        ifa.red_in = '0; ifa.green_in = '0; ifa.blue_in = '0;
        ifb.red_in = '0; ifb.green_in = '0; ifb.blue_in = '0;
        hist_reset();

        // reset, pix_en ignored in reset, hold while low, de on 3rd tick after release
        tbl[0] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 4, 0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].e);
            chk("tbl_h", int'(ifa.req_x), tbl[i].h);
            chk("tbl_v", int'(ifa.req_y), tbl[i].v);
            chk("tbl_line_start", int'(ifa.line_start), int'(tbl[i].ls));
            chk("tbl_frame_start", int'(ifa.frame_start), int'(tbl[i].fs));
            chk("tbl_de", int'(de_a), int'(tbl[i].de));
        end

        // Two free-running frames; pin totals over the second (steady-state) frame
        step(1'b1, 1'b1);
        n_hs_a = 0; n_vs_a = 0; n_de_a = 0; n_hs_b = 0; n_vs_b = 0; n_de_b = 0;
        n_ls = 0; n_fs = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'b0, 1'b1);
            if (i >= HT * VT) begin
                if (!hs_a) n_hs_a++;
                if (!vs_a) n_vs_a++;
                if (de_a)  n_de_a++;
                if (hs_b)  n_hs_b++;
                if (vs_b)  n_vs_b++;
                if (de_b)  n_de_b++;
                if (ifa.line_start)  n_ls++;
                if (ifa.frame_start) n_fs++;
            end
        end
        chk("frame_hsync_low_a", n_hs_a, HS * VT);
        chk("frame_vsync_low_a", n_vs_a, VS * HT);
        chk("frame_de_a", n_de_a, HA * VA);
        chk("frame_hsync_high_b", n_hs_b, HS * VT);
        chk("frame_vsync_high_b", n_vs_b, VS * HT);
        chk("frame_de_b", n_de_b, HA * VA);
        chk("frame_line_starts", n_ls, VT);
        chk("frame_frame_starts", n_fs, 1);

        // pix_en toggling every clock doubles every period
        step(1'b1, 1'b1);
        prev_ls = 1; prev_fs = 1;
        for (int i = 0; i < 4 * HT * VT + 40; i++) begin
            step(1'b0, (i % 2) == 0);
            if (ifa.line_start && prev_ls == 0) ls_rise.push_back(i);
            if (ifa.frame_start && prev_fs == 0) fs_rise.push_back(i);
            prev_ls = int'(ifa.line_start);
            prev_fs = int'(ifa.frame_start);
        end
        chk("toggle_line_rises", int'(ls_rise.size() >= 2), 1);
        chk("toggle_frame_rises", int'(fs_rise.size() >= 2), 1);
        if (ls_rise.size() >= 2) chk("toggle_line_period", ls_rise[1] - ls_rise[0], 2 * HT);
        if (fs_rise.size() >= 2) chk("toggle_frame_period", fs_rise[1] - fs_rise[0], 2 * HT * VT);

        // Reset mid-frame at h=5, v=2
        step(1'b1, 1'b1);
        for (int i = 0; i < 2 * HT + 5; i++) step(1'b0, 1'b1);
        chk("pre_reset_x", int'(ifa.req_x), 5);
        chk("pre_reset_y", int'(ifa.req_y), 2);
        step(1'b1, 1'b1);
        chk("mid_reset_x", int'(ifa.req_x), 0);
        chk("mid_reset_y", int'(ifa.req_y), 0);
        chk("mid_reset_frame_start", int'(ifa.frame_start), 1);
        chk("mid_reset_de_a", int'(de_a), 0);
        chk("mid_reset_hsync_a", int'(hs_a), 1);
        chk("mid_reset_vsync_b", int'(vs_b), 0);
        first_a = -1; first_b = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1);
            if (de_a && first_a < 0) first_a = k;
            if (de_b && first_b < 0) first_b = k;
        end
        chk("de_rise_ticks_a", first_a, LAT_A + 1);
        chk("de_rise_ticks_b", first_b, LAT_B + 1);

        // Random pix_en with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
